fifo_push_arbiter: RTL and testbench

Round-robin, packet-locked arbiter that shares one 8-bit, 32-entry FIFO write port (push/push_data/full) among NUM_REQ requesters.
- Each requester uses a valid/ready/last handshake.
- Once granted, a requester keeps the FIFO until it transfers its last beat or stalls past a timeout.
- Sits between peripheral/bus-side producers and the shared TX FIFO.

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/fifo_push_arbiter_if.sv | 29 ++
 rtl/fifo_push_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_push_arbiter.sv | 98 +++++++++
 tb/tb_fifo_push_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default constants for the FIFO push arbiter
package fifo_arb_pkg;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;
endpackage

// File: rtl/fifo_push_arbiter_if.sv
// rtl/fifo_push_arbiter_if.sv - requester handshakes, FIFO write port and arbiter status
interface fifo_push_arbiter_if #(
    parameter int NUM_REQ = fifo_arb_pkg::DEF_NUM_REQ,
    parameter int DATA_W  = fifo_arb_pkg::DEF_DATA_W
);
    import fifo_arb_pkg::*;
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_push;
    logic [DATA_W-1:0]         fifo_push_data;
    logic                      fifo_full;
    logic [IDX_W-1:0]          grant_id;
    logic                      busy;
    logic                      err_timeout;

    // master: the arbiter; slave: requesters, FIFO and status observers
    modport master (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_push, fifo_push_data, grant_id, busy, err_timeout
    );
    modport slave (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_push, fifo_push_data, grant_id, busy, err_timeout
    );
endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// rtl/fifo_push_arbiter_rr_pick.sv - combinational round-robin search starting after rr_last
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_last,
    output logic [IDX_W-1:0]   pick,
    output logic               any_req
);
    function automatic logic [IDX_W-1:0] wrap(input int v);
        return (v >= NUM_REQ) ? IDX_W'(v - NUM_REQ) : IDX_W'(v);
    endfunction

    // Scan farthest-first so the nearest requester after rr_last wins last.
    always_comb begin
        pick = rr_last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[wrap(int'(rr_last) + k)]) begin
                pick = wrap(int'(rr_last) + k);
            end
        end
    end

    assign any_req = |req;
endmodule

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - packet-locked round-robin arbiter sharing one FIFO write port
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    fifo_push_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT - 1);

    arb_state_e       state, state_nxt;
    logic [IDX_W-1:0] grant_id, rr_last, pick;
    logic [CNT_W-1:0] stall_cnt;
    logic             any_req, busy, err_timeout;
    logic             g_valid, g_last, xfer, timeout_hit;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req     (bus.req_valid),
        .rr_last (rr_last),
        .pick    (pick),
        .any_req (any_req)
    );

    assign g_valid     = bus.req_valid[grant_id];
    assign g_last      = bus.req_last[grant_id];
    assign xfer        = (state == LOCK) && g_valid && !bus.fifo_full;
    assign timeout_hit = (state == LOCK) && !g_valid && (stall_cnt == STALL_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = LOCK;
            LOCK:    if ((xfer && g_last) || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.fifo_push = 1'b0;
        if (state == LOCK) begin
            bus.req_ready[grant_id] = !bus.fifo_full;
            bus.fifo_push           = g_valid && !bus.fifo_full;
        end
    end

    assign bus.fifo_push_data = bus.req_data[grant_id*DATA_W +: DATA_W];

    // Back-pressure with valid held breaks a stall run; only a missing beat counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id    <= '0;
            rr_last     <= IDX_W'(NUM_REQ - 1);
            stall_cnt   <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id  <= pick;
                        busy      <= 1'b1;
                        stall_cnt <= '0;
                    end
                end
                LOCK: begin
                    if ((xfer && g_last) || timeout_hit) begin
                        rr_last     <= grant_id;
                        busy        <= 1'b0;
                        stall_cnt   <= '0;
                        err_timeout <= timeout_hit;
                    end else if (!g_valid) begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end else begin
                        stall_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.grant_id    = grant_id;
    assign bus.busy        = busy;
    assign bus.err_timeout = err_timeout;
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - table, directed and randomized checks of fifo_push_arbiter
module tb_fifo_push_arbiter;
    import fifo_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_push_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    fifo_push_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the port, who won last, how long the owner has been silent.
    bit m_locked;
    int m_owner, m_prev, m_silent;
    bit m_err;

    int n_push, n_55, n_err;
    bit r0_seen;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        full;
        logic [3:0]  exp_ready;
        logic        exp_push;
        logic [7:0]  exp_pdata;
        logic [1:0]  exp_grant;
        logic        exp_busy;
        logic        exp_err;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic f);
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        bus.fifo_full = f;
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_prev   = NR - 1;
        m_silent = 0;
        m_err    = 0;
    endtask

    task automatic model_step();
        logic [3:0] v;
        logic [3:0] l;
        v = bus.req_valid;
        l = bus.req_last;
        m_err = 0;
        if (!m_locked) begin
            if (v != 0) begin
                for (int k = 1; k <= NR; k++) begin
                    int c = (m_prev + k) % NR;
                    if (v[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_locked = 1;
                m_silent = 0;
            end
        end else if (v[m_owner] && !bus.fifo_full) begin
            m_silent = 0;
            if (l[m_owner]) begin
                m_locked = 0;
                m_prev   = m_owner;
            end
        end else if (!v[m_owner]) begin
            m_silent++;
            if (m_silent == TO) begin
                m_err    = 1;
                m_locked = 0;
                m_prev   = m_owner;
                m_silent = 0;
            end
        end else begin
            m_silent = 0;
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic do_cycle();
        logic [3:0] er;
        logic       ep;
        #2;
        er = '0;
        ep = 1'b0;
        if (m_locked) begin
            er[m_owner] = !bus.fifo_full;
            ep          = bus.req_valid[m_owner] && !bus.fifo_full;
        end
        chk("req_ready", bus.req_ready, er);
        chk("fifo_push", bus.fifo_push, ep);
        if (ep) chk("push_data", bus.fifo_push_data, bus.req_data[m_owner*DW +: DW]);
        if (bus.fifo_push) n_push++;
        if (bus.fifo_push && bus.fifo_push_data == 8'h55) n_55++;
        if (bus.req_ready[0]) r0_seen = 1;
        @(posedge clk);
        model_step();
        #1;
        chk("grant_id", bus.grant_id, m_owner);
        chk("busy", bus.busy, m_locked);
        chk("err_timeout", bus.err_timeout, m_err);
        if (bus.err_timeout) n_err++;
    endtask

    task automatic apply_vec(input vec_t t);
        drive(t.valid, t.last, t.data, t.full);
        #2;
        chk("tbl_ready", bus.req_ready, t.exp_ready);
        chk("tbl_push", bus.fifo_push, t.exp_push);
        if (t.exp_push) chk("tbl_pdata", bus.fifo_push_data, t.exp_pdata);
        @(posedge clk);
        model_step();
        #1;
        chk("tbl_grant", bus.grant_id, t.exp_grant);
        chk("tbl_busy", bus.busy, t.exp_busy);
        chk("tbl_err", bus.err_timeout, t.exp_err);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_grant", bus.grant_id, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err_timeout, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_push", bus.fifo_push, 0);
    endtask

    initial begin
        int err_at;

        // single requester, three beats
        tbl.push_back('{4'b0010, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{4'b0010, 4'b0000, 32'h0000_A100, 1'b0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{4'b0010, 4'b0000, 32'h0000_A200, 1'b0, 4'b0010, 1'b1, 8'hA2, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{4'b0010, 4'b0010, 32'h0000_A300, 1'b0, 4'b0010, 1'b1, 8'hA3, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0, 1'b0});
        // all four valid with one-beat packets: order 0,1,2,3 then 0 again
        tbl.push_back('{4'b1111, 4'b1111, 32'h4433_2211, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{4'b1111, 4'b1111, 32'h4433_2211, 1'b0, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{4'b1110, 4'b1111, 32'h4433_2211, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{4'b1110, 4'b1111, 32'h4433_2211, 1'b0, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{4'b1100, 4'b1111, 32'h4433_2211, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{4'b1100, 4'b1111, 32'h4433_2211, 1'b0, 4'b0100, 1'b1, 8'h33, 2'd2, 1'b0, 1'b0});
        tbl.push_back('{4'b1000, 4'b1111, 32'h4433_2211, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{4'b1000, 4'b1111, 32'h4433_2211, 1'b0, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b0, 1'b0});
        tbl.push_back('{4'b0001, 4'b1111, 32'h4433_2211, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{4'b0001, 4'b1111, 32'h4433_2211, 1'b0, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b0, 1'b0});

        do_reset();
        for (int i = 0; i < 5; i++) apply_vec(tbl[i]);
        do_reset();
        for (int i = 5; i < tbl.size(); i++) apply_vec(tbl[i]);

        // back-pressure on beat 2 of requester 2
        do_reset();
        drive(4'b0100, 4'b0000, 32'h0054_0000, 1'b0); do_cycle();
        do_cycle();
        n_push = 0; n_55 = 0; n_err = 0;
        drive(4'b0100, 4'b0000, 32'h0055_0000, 1'b1);
        repeat (5) do_cycle();
        chk("bp_no_push", n_push, 0);
        drive(4'b0100, 4'b0000, 32'h0055_0000, 1'b0); do_cycle();
        drive(4'b0100, 4'b0100, 32'h0056_0000, 1'b0); do_cycle();
        chk("bp_55_once", n_55, 1);
        chk("bp_no_timeout", n_err, 0);
        chk("bp_released", bus.busy, 0);

        // timeout: requester 3 sends one non-last beat then goes silent
        do_reset();
        drive(4'b1000, 4'b0000, 32'h7700_0000, 1'b0); do_cycle();
        do_cycle();
        drive(4'b0000, 4'b0000, 32'h0, 1'b0);
        n_err = 0; err_at = -1;
        for (int k = 1; k <= 30; k++) begin
            do_cycle();
            if (bus.err_timeout && err_at < 0) err_at = k;
        end
        chk("to_cycle", err_at, 16);
        chk("to_pulses", n_err, 1);
        chk("to_busy", bus.busy, 0);
        drive(4'b0001, 4'b0000, 32'h0, 1'b0); do_cycle();
        chk("to_next_grant", bus.grant_id, 0);

        // packet lock: requester 0 waits out requester 1's four-beat packet
        do_reset();
        drive(4'b0010, 4'b0000, 32'h0, 1'b0); do_cycle();
        r0_seen = 0;
        for (int b = 0; b < 4; b++) begin
            drive(4'b0011, (b == 3) ? 4'b0010 : 4'b0000, 32'h0000_C000 | 32'(b << 8), 1'b0);
            do_cycle();
        end
        chk("lock_r0_ready", r0_seen, 0);
        drive(4'b0101, 4'b0000, 32'h0, 1'b0); do_cycle();
        chk("lock_next_grant", bus.grant_id, 2);

        // asynchronous reset while pushing
        do_reset();
        drive(4'b0001, 4'b0000, 32'h0000_00AB, 1'b0); do_cycle();
        #2;
        chk("ar_push_before", bus.fifo_push, 1);
        #1 rst = 1'b1;
        #1;
        chk("ar_push", bus.fifo_push, 0);
        chk("ar_ready", bus.req_ready, 0);
        chk("ar_busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        drive(4'b1111, 4'b0000, 32'h0, 1'b0); do_cycle();
        chk("ar_first_grant", bus.grant_id, 0);

        // randomized traffic: busy phase, then sparse phase to reach timeouts
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            logic [3:0] v;
            int pct;
            pct = (i < 600) ? 70 : 8;
            for (int r = 0; r < NR; r++) v[r] = ($urandom_range(99) < pct);
            drive(v, 4'($urandom_range(15)) & 4'($urandom_range(15)), $urandom, ($urandom_range(4) == 0));
            do_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
